cnn_fmap_mem_arbiter: RTL and testbench
=======================================

# cnn_fmap_mem_arbiter

Arbitrates one single-port synchronous feature-map SRAM between the CNN layer engines (Conv0, Pool0, Conv1, Pool1, FC0). It grants the memory to one requester at a time for a bounded burst, muxes that requester's address, write-enable and write-data onto the SRAM port, and routes read data back with a one-cycle-delayed valid strobe. It sits between the layer engines and the shared buffer, under the CNN control unit's sequencing.

## Interface
- NUM_REQ, 5, number of requesters; index 0 = Conv0 … 4 = FC0
- ADDR_W, 12, SRAM address width
- DATA_W, 8, SRAM data width
- MAX_BURST, 16, maximum beats per grant; must be ≥1

Ports:
- CNN_Arb_CLOCK_50  in  1  single clock; all logic on its rising edge
- CNN_Arb_RESET_InLow  in  1  reset; asynchronous, active-low
- CNN_Arb_Req_InHigh  in  NUM_REQ  per-requester request / beat-valid
- CNN_Arb_Last_InHigh  in  NUM_REQ  marks the final beat of the owner's burst
- CNN_Arb_Addr_In  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- CNN_Arb_WrEn_In  in  NUM_REQ  1 = write beat, 0 = read beat
- CNN_Arb_WrData_In  in  NUM_REQ*DATA_W  flattened write data
- CNN_Arb_Mem_RdData_In  in  DATA_W  SRAM read data, valid one cycle after a read beat
- CNN_Arb_Grant_Out  out  NUM_REQ  one-hot registered grant; all-zero when no owner
- CNN_Arb_Mem_En_Out  out  1  SRAM enable; high only on a beat
- CNN_Arb_Mem_WrEn_Out  out  1  SRAM write enable
- CNN_Arb_Mem_Addr_Out  out  ADDR_W  SRAM address
- CNN_Arb_Mem_WrData_Out  out  DATA_W  SRAM write data
- CNN_Arb_RdData_Out  out  DATA_W  read data, direct from CNN_Arb_Mem_RdData_In
- CNN_Arb_RdValid_Out  out  NUM_REQ  one-hot read-data-valid for the issuing requester
- CNN_Arb_Busy_Out  out  1  high while in ST_BURST

## Operation
- States: ST_IDLE, ST_BURST.
- ST_IDLE: if any Req bit is high, pick a winner (policy below), register one-hot Grant and owner index, clear the beat counter, go to ST_BURST. No beats issue in ST_IDLE.
- ST_BURST: a beat occurs on every cycle with Req[owner]=1. Mem_En=1, and WrEn/Addr/WrData come from the owner's slice combinationally. Each beat increments the beat counter (width clog2(MAX_BURST+1)).
- Burst ends on a beat with Last[owner]=1, or on the beat where the counter reaches MAX_BURST (forced release). On the next edge, Grant clears and the FSM returns to ST_IDLE.
- Owner drops Req mid-burst: no beat, counter holds, grant is kept. Last without Req is ignored.
- Non-owner Req/Last inputs are ignored during ST_BURST.
- When Mem_En=0, the Mem_Addr/WrData/WrEn outputs are driven to 0.
- Read beat (WrEn[owner]=0): RdValid_Out[owner] pulses high exactly one cycle later. This holds even if the grant has already been released.
- Default policy is fixed priority: the lowest index wins.

## Timing
- Reset (asynchronous, low): state ST_IDLE, Grant=0, counter=0, RdValid=0, Busy=0, Mem_En=0, Mem_WrEn=0, Mem_Addr=0, Mem_WrData=0, last-owner pointer=NUM_REQ-1. RdData_Out follows the SRAM.
- Reset asserted mid-burst aborts the burst immediately. A pending RdValid is dropped.
- Req rises at edge N (seen at N) → Grant high after edge N, first beat possible in cycle N+1.
- Each burst costs one dead ST_IDLE cycle before the next grant. Back-to-back owners therefore see a one-cycle gap.
- Write beat: SRAM captures at the end of the beat cycle. Read beat in cycle k → RdData/RdValid valid in cycle k+1.

## Configuration
- CNN_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - The winner is the first requesting index after the last owner, scanning upward with wrap-around.
  - The last-owner pointer updates at grant.
- Not defined: fixed priority, lowest index wins. The pointer register is not built.

## Test plan
- Reset then idle: all outputs 0; Req=5'b00100 → Grant=5'b00100 after one edge. Four writes to addr 0x010–0x013 with Last on the 4th → Grant=0 after the 4th beat, Busy falls.
- Read burst: Req[1], 3 reads with data 0xA1, 0xA2, 0xA3 → RdValid=5'b00010 in each following cycle, including the cycle after release.
- Forced release: Req[0] held with Last=0, MAX_BURST=16 → exactly 16 Mem_En pulses, then Grant=0 for one cycle, then re-grant.
- Contention Req=5'b10011 over three consecutive bursts → fixed: grants 0,0,0; with CNN_ARB_ROUND_ROBIN_EN: 0,1,4.
- Owner bubbles: Req[3] toggles 1,0,0,1 with Last on the 2nd beat → 2 beats, counter=2 at release, grant held through bubbles.
- Reset asserted mid-burst after beat 2 of 5 → Grant=0, Mem_En=0 immediately, pending RdValid suppressed; first request after reset is arbitrated normally.

Source files
------------

// File: rtl/cnn_fmap_mem_arbiter.sv
// cnn_fmap_mem_arbiter: shares one feature-map SRAM port among the CNN layer engines in bounded bursts.
// Ports: CNN_Arb_CLOCK_50 clock, CNN_Arb_RESET_InLow async active-low reset;
//   per-requester Req/Last/WrEn and flattened Addr/WrData in; SRAM En/WrEn/Addr/WrData out,
//   SRAM read data in and passed through on RdData_Out with a one-hot RdValid_Out one cycle after a read beat;
//   Grant_Out one-hot owner, Busy_Out high during a burst.
// Define CNN_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module cnn_fmap_mem_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      CNN_Arb_CLOCK_50,
  input  logic                      CNN_Arb_RESET_InLow,
  input  logic [NUM_REQ-1:0]        CNN_Arb_Req_InHigh,
  input  logic [NUM_REQ-1:0]        CNN_Arb_Last_InHigh,
  input  logic [NUM_REQ*ADDR_W-1:0] CNN_Arb_Addr_In,
  input  logic [NUM_REQ-1:0]        CNN_Arb_WrEn_In,
  input  logic [NUM_REQ*DATA_W-1:0] CNN_Arb_WrData_In,
  input  logic [DATA_W-1:0]         CNN_Arb_Mem_RdData_In,
  output logic [NUM_REQ-1:0]        CNN_Arb_Grant_Out,
  output logic                      CNN_Arb_Mem_En_Out,
  output logic                      CNN_Arb_Mem_WrEn_Out,
  output logic [ADDR_W-1:0]         CNN_Arb_Mem_Addr_Out,
  output logic [DATA_W-1:0]         CNN_Arb_Mem_WrData_Out,
  output logic [DATA_W-1:0]         CNN_Arb_RdData_Out,
  output logic [NUM_REQ-1:0]        CNN_Arb_RdValid_Out,
  output logic                      CNN_Arb_Busy_Out
);
  localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
  state_t state, state_nx;
  logic [NUM_REQ-1:0] grant_nx, rd_valid_nx;
  logic [OW-1:0] owner, owner_nx, win;
  logic [CW-1:0] cnt, cnt_nx;
  logic found, beat, burst_end;
`ifdef CNN_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] ptr;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++)
      if (!found && CNN_Arb_Req_InHigh[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = OW'((int'(ptr) + i) % NUM_REQ);
      end
  end
  always_ff @(posedge CNN_Arb_CLOCK_50 or negedge CNN_Arb_RESET_InLow)
    if (!CNN_Arb_RESET_InLow) ptr <= OW'(NUM_REQ - 1);
    else if (state == ST_IDLE && found) ptr <= win;
`else
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (CNN_Arb_Req_InHigh[i]) begin
        found = 1'b1;
        win = OW'(i);
      end
  end
`endif
  assign beat = state == ST_BURST && CNN_Arb_Req_InHigh[owner];
  // The counter still holds the pre-beat count, so MAX_BURST-1 marks the final allowed beat.
  assign burst_end = beat && (CNN_Arb_Last_InHigh[owner] || cnt == CW'(MAX_BURST - 1));
  assign CNN_Arb_Mem_En_Out = beat;
  assign CNN_Arb_Mem_WrEn_Out = beat && CNN_Arb_WrEn_In[owner];
  assign CNN_Arb_Mem_Addr_Out = beat ? CNN_Arb_Addr_In[int'(owner)*ADDR_W +: ADDR_W] : '0;
  assign CNN_Arb_Mem_WrData_Out = beat ? CNN_Arb_WrData_In[int'(owner)*DATA_W +: DATA_W] : '0;
  assign CNN_Arb_RdData_Out = CNN_Arb_Mem_RdData_In;
  assign CNN_Arb_Busy_Out = state == ST_BURST;
  // Grant is one-hot on the owner during a burst, so it doubles as the read-valid vector.
  assign rd_valid_nx = beat && !CNN_Arb_WrEn_In[owner] ? CNN_Arb_Grant_Out : '0;
  always_comb begin
    state_nx = state;
    grant_nx = CNN_Arb_Grant_Out;
    owner_nx = owner;
    cnt_nx = cnt;
    if (state == ST_IDLE && found) begin
      state_nx = ST_BURST;
      grant_nx = NUM_REQ'(1) << win;
      owner_nx = win;
      cnt_nx = '0;
    end else if (beat) begin
      cnt_nx = cnt + 1'b1;
      state_nx = burst_end ? ST_IDLE : ST_BURST;
      grant_nx = burst_end ? '0 : CNN_Arb_Grant_Out;
    end
  end
  always_ff @(posedge CNN_Arb_CLOCK_50 or negedge CNN_Arb_RESET_InLow)
    if (!CNN_Arb_RESET_InLow) begin
      state <= ST_IDLE;
      CNN_Arb_Grant_Out <= '0;
      owner <= '0;
      cnt <= '0;
      CNN_Arb_RdValid_Out <= '0;
    end else begin
      state <= state_nx;
      CNN_Arb_Grant_Out <= grant_nx;
      owner <= owner_nx;
      cnt <= cnt_nx;
      CNN_Arb_RdValid_Out <= rd_valid_nx;
    end
endmodule

// File: tb/tb_cnn_fmap_mem_arbiter.sv
// tb_cnn_fmap_mem_arbiter: directed plus random checks of the SRAM arbiter against a behavioural model.
module tb_cnn_fmap_mem_arbiter;
  localparam int N = 5, AW = 12, DW = 8, MB = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, last = '0, wren = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata = '0;
  logic [N-1:0] grant, rd_valid;
  logic mem_en, mem_wren, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rd_out;
  int tests = 0, fails = 0;
  bit m_busy;
  int m_owner, m_beats, m_ptr, en_cnt;
  logic [N-1:0] m_rdv;
  int glog[$];

  cnn_fmap_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .CNN_Arb_CLOCK_50(clk), .CNN_Arb_RESET_InLow(rst_n),
    .CNN_Arb_Req_InHigh(req), .CNN_Arb_Last_InHigh(last),
    .CNN_Arb_Addr_In(addr), .CNN_Arb_WrEn_In(wren), .CNN_Arb_WrData_In(wdata),
    .CNN_Arb_Mem_RdData_In(rdata), .CNN_Arb_Grant_Out(grant),
    .CNN_Arb_Mem_En_Out(mem_en), .CNN_Arb_Mem_WrEn_Out(mem_wren),
    .CNN_Arb_Mem_Addr_Out(mem_addr), .CNN_Arb_Mem_WrData_Out(mem_wdata),
    .CNN_Arb_RdData_Out(rd_out), .CNN_Arb_RdValid_Out(rd_valid), .CNN_Arb_Busy_Out(busy));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(int i);
    return N'(1) << i;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = N - 1; m_rdv = '0;
  endtask

  task automatic check_all();
    bit b;
    b = m_busy && req[m_owner];
    if (mem_en === 1'b1) en_cnt++;
    chk("grant", grant, m_busy ? oh(m_owner) : '0);
    chk("busy", busy, m_busy);
    chk("rd_valid", rd_valid, m_rdv);
    chk("mem_en", mem_en, b);
    chk("mem_wren", mem_wren, b && wren[m_owner]);
    chk("mem_addr", mem_addr, b ? addr[m_owner*AW +: AW] : '0);
    chk("mem_wdata", mem_wdata, b ? wdata[m_owner*DW +: DW] : '0);
    chk("rd_data", rd_out, rdata);
  endtask

  task automatic model_edge();
    bit b;
    int w;
    logic [N-1:0] nrdv;
    if (!rst_n) begin model_reset(); return; end
    b = m_busy && req[m_owner];
    nrdv = (b && !wren[m_owner]) ? oh(m_owner) : '0;
    if (!m_busy) begin
      w = -1;
`ifdef CNN_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`else
      for (int k = N - 1; k >= 0; k--) if (req[k]) w = k;
`endif
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_beats = 0; m_ptr = w; glog.push_back(w);
      end
    end else if (b) begin
      m_beats++;
      if (last[m_owner] || m_beats == MB) m_busy = 0;
    end
    m_rdv = nrdv;
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances through the next edge.
  task automatic cyc();
    rdata = DW'($urandom);
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; last = '0; wren = '0;
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int b;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    cyc();
    // single write burst by Pool0 index 2
    req = 5'b00100; wren = 5'b00100;
    cyc();
    chk("t1_grant", grant, 5'b00100);
    for (int k = 0; k < 4; k++) begin
      addr[2*AW +: AW] = AW'(12'h010 + k);
      wdata[2*DW +: DW] = DW'($urandom);
      last[2] = (k == 3);
      cyc();
    end
    req = '0; last = '0; wren = '0;
    #1 chk("t1_release", {grant, busy}, 6'b0);
    cyc();
    // read burst by index 1
    req = 5'b00010;
    cyc();
    for (int k = 0; k < 3; k++) begin
      addr[1*AW +: AW] = AW'($urandom);
      last[1] = (k == 2);
      cyc();
      chk("t2_rdv", rd_valid, 5'b00010);
    end
    req = '0; last = '0;
    cyc();
    // forced release after MAX_BURST beats
    req = 5'b00001; wren = 5'b00001; en_cnt = 0;
    for (int k = 0; k < MB + 1; k++) cyc();
    #1 chk("t3_gap_grant", grant, 5'b0);
    cyc();
    chk("t3_en_pulses", en_cnt, MB);
    chk("t3_regrant", grant, 5'b00001);
    last = 5'b00001;
    cyc();
    req = '0; last = '0; wren = '0;
    cyc();
    // contention over three bursts from a fresh reset
    do_reset();
    glog.delete();
    req = 5'b10011; last = 5'b11111;
    for (int k = 0; k < 6; k++) cyc();
    req = '0; last = '0;
    cyc();
    chk("t4_ngrants", glog.size(), 3);
`ifdef CNN_ARB_ROUND_ROBIN_EN
    chk("t4_order", {glog[0][3:0], glog[1][3:0], glog[2][3:0]}, 12'h014);
`else
    chk("t4_order", {glog[0][3:0], glog[1][3:0], glog[2][3:0]}, 12'h000);
`endif
    // owner bubbles on index 3
    req = 5'b01000; en_cnt = 0;
    cyc();
    req = 5'b01000; cyc();
    req = 5'b00000; cyc();
    chk("t5_held", grant, 5'b01000);
    cyc();
    req = 5'b01000; last = 5'b01000; cyc();
    chk("t5_beats", en_cnt, 2);
    req = '0; last = '0;
    cyc();
    // reset mid read burst on index 4
    req = 5'b10000;
    cyc();
    cyc(); cyc();
    rst_n = 1'b0;
    model_reset();
    #1 chk("t6_abort", {grant, mem_en, rd_valid}, 11'b0);
    cyc();
    rst_n = 1'b1; req = 5'b00001; last = 5'b00001;
    cyc();
    chk("t6_regrant", grant, 5'b00001);
    cyc();
    req = '0; last = '0;
    cyc();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      req = N'($urandom); b = $urandom_range(0, 3); last = b == 0 ? N'($urandom) : '0;
      wren = N'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      rst_n = $urandom_range(0, 99) != 0;
      if (!rst_n) model_reset();
      cyc();
      rst_n = 1'b1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
